// File: rtl/panel_led_shifter_pkg.sv
// Shared front-panel definitions: shifter FSM states, frame geometry and
// the frame-vector builder used at snapshot time.
package panel_led_shifter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    GAP
  } state_t;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned ADDR_LSB   = 14;
  localparam int unsigned DATA_MSB   = 15;
  localparam int unsigned RUN_BIT    = 27;

  // frame[0] is the first bit shifted out.
  typedef logic [0:FRAME_BITS-1] frame_t;

  // {addr, data, run_led, 4'b0000}; lamp test lights every lamp bit but
  // leaves the four spare trailing bits dark.
  function automatic frame_t build_frame(input logic [0:14] addr,
                                         input logic [0:11] data,
                                         input logic        run_led,
                                         input logic        lamp_test);
    frame_t f;
    f = '0;
    if (lamp_test) begin
      f[0:RUN_BIT] = '1;
    end else begin
      f[0:ADDR_LSB]          = addr;
      f[DATA_MSB:RUN_BIT-1] = data;
      f[RUN_BIT]             = run_led;
    end
    return f;
  endfunction

endpackage

// File: rtl/panel_led_shifter_if.sv
// Panel shifter bus: lamp sources from the display mux plus control
// (enable, lamp_test) and the serial chain / status outputs.
//   master : drives lamp sources and control, observes chain and status
//   slave  : the shifter itself
interface panel_led_shifter_if;
  logic        enable;
  logic        lamp_test;
  logic [0:11] data;
  logic        run_led;
  logic [0:14] addr;
  logic        sclk;
  logic        sdata;
  logic        slatch;
  logic        busy;
  logic        frame_done;

  modport master (
    output enable, lamp_test, data, run_led, addr,
    input  sclk, sdata, slatch, busy, frame_done
  );

  modport slave (
    input  enable, lamp_test, data, run_led, addr,
    output sclk, sdata, slatch, busy, frame_done
  );
endinterface

// File: rtl/panel_clk_div.sv
// Half-period tick generator for the panel shifter.
//   clk, reset : system clock, async active-low reset
//   restart    : clears the count (asserted on every state entry)
//   tick       : last cycle of a CLK_DIV-cycle interval
//   pre_tick   : cycle before tick (never asserted when CLK_DIV == 1)
module panel_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] PRE  = 8'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

  logic [7:0] cnt;

  // Saturates at LAST so an un-restarted count can never wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick     = (cnt == LAST);
  assign pre_tick = (CLK_DIV > 1) && (cnt == PRE);

endmodule

// File: rtl/panel_led_shifter.sv
// Front-panel LED shifter: snapshots address/data/run lamps once per frame
// and serialises them MSB-first (frame[0] first) into a 74HC595 chain,
// followed by a latch pulse and an idle gap.
//   clk, reset : system clock, async active-low reset
//   bus        : panel_led_shifter_if.slave (lamp inputs, control,
//                sclk/sdata/slatch chain drive, busy/frame_done status)
module panel_led_shifter
  import panel_led_shifter_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  panel_led_shifter_if.slave   bus
);

  localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [4:0]  LAST_BIT = 5'(FRAME_BITS - 1);

  state_t      state;
  frame_t      frame;
  frame_t      snap;
  logic [4:0]  index;
  logic [15:0] gap_cnt;
  logic        sclk_r, sdata_r, slatch_r, busy_r, done_r;
  logic        tick, pre_tick, div_restart;

  assign snap = build_frame(bus.addr, bus.data, bus.run_led, bus.lamp_test);

  // Timed states hold the divider running; a tick ends the state and the
  // restart lands exactly on the next state's first cycle.
  assign div_restart = tick || !(state inside {SHIFT_LO, SHIFT_HI, LATCH});

  panel_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk      (clk),
    .reset    (reset),
    .restart  (div_restart),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // Outputs are set on the edge entering each state, so they are valid for
  // the whole state. The frame is captured on the edge entering LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      frame    <= '0;
      index    <= '0;
      gap_cnt  <= '0;
      sclk_r   <= 1'b0;
      sdata_r  <= 1'b0;
      slatch_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state  <= LOAD;
            frame  <= snap;
            busy_r <= 1'b1;
          end
        end
        LOAD: begin
          state   <= SHIFT_LO;
          index   <= '0;
          sdata_r <= frame[0];
        end
        SHIFT_LO: begin
          if (tick) begin
            state  <= SHIFT_HI;
            sclk_r <= 1'b1;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            sclk_r <= 1'b0;
            if (index == LAST_BIT) begin
              state    <= LATCH;
              sdata_r  <= 1'b0;
              slatch_r <= 1'b1;
              // A one-cycle LATCH is its own final cycle.
              done_r   <= (CLK_DIV == 1);
            end else begin
              state   <= SHIFT_LO;
              index   <= index + 5'd1;
              sdata_r <= frame[index + 5'd1];
            end
          end
        end
        LATCH: begin
          done_r <= pre_tick;
          if (tick) begin
            slatch_r <= 1'b0;
            if (GAP_CYCLES != 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LAST;
            end else if (bus.enable) begin
              state <= LOAD;
              frame <= snap;
            end else begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (bus.enable) begin
              state <= LOAD;
              frame <= snap;
            end else begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk       = sclk_r;
  assign bus.sdata      = sdata_r;
  assign bus.slatch     = slatch_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = done_r;

endmodule

// File: doc/panel_led_shifter.md
Name: panel_led_shifter

Overview:
- Downstream consumer of the front-panel display mux's 12-bit data word and run lamp.
- Each frame it snapshots the word, the 15-bit memory-address lamps and the run lamp, then serialises them into a chain of 74HC595-style shift registers driving the physical panel LEDs.
- Runs continuously, so the lamps refresh at a fixed rate.
- Supports lamp test and a clean stop at a frame boundary.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period. Legal values are 1 to 255.
- GAP_CYCLES, 64: idle clk cycles between a latch pulse and the next snapshot. Legal values are 0 to 65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  when high, frames run back-to-back; when low, the block stops at the next frame boundary.
- lamp_test  in  1  when high at snapshot, all lamp bits are forced to 1.
- data  in  [0:11]  display word from the display mux.
- run_led  in  1  run lamp from the display mux.
- addr  in  [0:14]  EMA (extended address) and MA lamps; bit 0 is EMA0.
- sclk  out  1  shift clock to the register chain.
- sdata  out  1  serial data to the register chain.
- slatch  out  1  storage-register latch strobe, active high.
- busy  out  1  high from LOAD through GAP inclusive.
- frame_done  out  1  one-clk pulse on the last cycle of LATCH.

Behaviour:
- Reset:
  - Asserting reset low immediately forces sclk=0, sdata=0, slatch=0, busy=0, frame_done=0.
  - The FSM goes to IDLE and the counters clear.
  - Reset can hit mid-frame: the partial frame is abandoned with no latch pulse.
- Frame vector frame[0:31] = {addr[0:14], data[0:11], run_led, 4'b0000}.
  - When lamp_test=1, bits 0 to 27 are 1 and bits 28 to 31 stay 0.
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, GAP.
- IDLE:
  - Outputs 0.
  - If enable=1, go to LOAD on the next clk.
- LOAD (1 cycle):
  - Register the frame vector and set bit index = 0.
  - Inputs that change after LOAD do not affect the current frame.
- SHIFT_LO (CLK_DIV cycles):
  - sclk=0 and sdata=frame[index].
  - sdata changes only on entry to SHIFT_LO.
- SHIFT_HI (CLK_DIV cycles):
  - sclk=1 and sdata is held.
  - On exit, if index==31 go to LATCH; otherwise index+1 and go to SHIFT_LO.
- Bit order: frame[0] is shifted first, frame[31] last. Exactly 32 rising sclk edges per frame.
- LATCH (CLK_DIV cycles):
  - sclk=0, sdata=0, slatch=1.
  - frame_done=1 on the final cycle.
- GAP (GAP_CYCLES cycles, skipped when 0):
  - All serial outputs are 0.
  - Exit to LOAD if enable=1, else to IDLE.
- enable dropping mid-frame does not truncate the frame: it completes through LATCH and GAP, then goes to IDLE.
- Frame period = 1 + 64*CLK_DIV + CLK_DIV + GAP_CYCLES clks.
  - Defaults: 1 + 256 + 4 + 64 = 325.
- The divider counter is 8 bits, the gap counter 16 bits and the bit index 5 bits. Counters reload on every state entry; there is no wrap-around dependence.
- lamp_test toggling within a frame takes effect at the next LOAD only.
- All outputs are registered with no combinational paths from inputs to outputs.

Decomposition:
- The shared front-panel package holds:
  - the FSM state encoding;
  - FRAME_BITS=32;
  - the frame bit-field offsets ADDR_LSB=14, DATA_MSB=15, RUN_BIT=27.
- One natural sub-module, panel_clk_div: the CLK_DIV half-period tick generator, restartable on state entry.
- The FSM, frame register and index counter stay in the top module.

Test Plan:
- Basic frame (CLK_DIV=2, GAP_CYCLES=4, enable=1, addr=15'o12345, data=12'o7070, run_led=1):
  - 32 bits sampled on sclk rising edges = 001010011100101_111000111000_1_0000;
  - slatch high 2 clks, frame_done pulses once;
  - next LOAD 135 clks after the previous LOAD.
- Lamp test (lamp_test=1, data=0, addr=0, run_led=0):
  - captured bits = 28 ones followed by 4 zeros.
- Snapshot isolation: change data from 12'o0000 to 12'o7777 at bit 5 of the shift.
  - That frame shows data=0; the next frame shows 12'o7777.
- Enable stop: drop enable during bit 10.
  - The frame completes with 32 edges, one latch and a full GAP, then goes to IDLE with busy=0.
  - There is no further sclk activity until enable=1, after which LOAD follows on the next clk.
- Mid-frame reset: assert reset low at bit 20.
  - In the same cycle sclk, sdata, slatch and busy go to 0; there is no latch pulse.
  - After release with enable=1, a fresh frame starts from frame[0].
- Parameter corner (CLK_DIV=1, GAP_CYCLES=0):
  - sclk toggles every clk;
  - the period is 1+64+1+0=66 clks;
  - LATCH goes directly to LOAD.
